// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencer for the five-stage pipeline: RAW stalls in ID, branch
// flushes from EX, data-memory waits from MEM, plus stall/flush counters.
//
// state    | meaning
// RUN      | normal issue; resolves mem-wait, branch and RAW hazards by priority
// MEM_WAIT | whole pipe held until data memory answers or the wait times out
// ERROR    | memory never answered; pipe held until reset
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic             src_valid,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             forward_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             backend_freeze,
    output logic             err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic raw_ex, raw_mem, hazard, mem_stall;
    logic pc_frz, ifid_frz, ifid_fl, idex_fl, be_frz;

    assign raw_ex  = src_valid & ex_wb_en &
                     ((src1 == ex_dest) | (two_src & (src2 == ex_dest)));
    assign raw_mem = src_valid & mem_wb_en &
                     ((src1 == mem_dest) | (two_src & (src2 == mem_dest)));
    // With forwarding only a load in EX cannot be bypassed in time.
    assign hazard    = forward_en ? (raw_ex & ex_mem_r_en) : (raw_ex | raw_mem);
    assign mem_stall = mem_req & ~mem_ready;
    assign wait_inc  = wait_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        pc_frz   = 1'b0;
        ifid_frz = 1'b0;
        ifid_fl  = 1'b0;
        idex_fl  = 1'b0;
        be_frz   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    be_frz   = 1'b1;
                    wait_d   = '0;
                    state_d  = MEM_WAIT;
                end else if (branch_taken) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                end else if (hazard) begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    idex_fl  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    wait_d  = '0;
                    state_d = RUN;
                end else begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    be_frz   = 1'b1;
                    wait_d   = wait_inc;
                    if (wait_inc == WAIT_LAST) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ERROR: begin
                pc_frz   = 1'b1;
                ifid_frz = 1'b1;
                be_frz   = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Stage controls are forced quiet while reset is held.
    assign pc_freeze      = pc_frz   & reset_n;
    assign if_id_freeze   = ifid_frz & reset_n;
    assign if_id_flush    = ifid_fl  & reset_n;
    assign id_ex_flush    = idex_fl  & reset_n;
    assign backend_freeze = be_frz   & reset_n;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((pc_frz | be_frz) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_fl && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err         = err_q;
    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with small counters and a short
// memory timeout; expectations are queued as stimulus is driven.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W       = 4;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 8;

    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_HAZ  = 5'b11010;
    localparam logic [4:0] C_BR   = 5'b00110;
    localparam logic [4:0] C_FRZ  = 5'b11001;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [REG_W-1:0] src1, src2, ex_dest, mem_dest;
    logic             two_src, src_valid, ex_wb_en, ex_mem_r_en, mem_wb_en;
    logic             forward_en, branch_taken, mem_req, mem_ready;
    logic             pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze;
    logic             err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct packed {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       two_src;
        logic       src_valid;
        logic [3:0] ex_dest;
        logic       ex_wb_en;
        logic       ex_mem_r_en;
        logic [3:0] mem_dest;
        logic       mem_wb_en;
        logic       forward_en;
        logic       branch_taken;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    // ctl = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}
    // during the cycle; st/er/sc/fc are the values after its clock edge.
    typedef struct packed {
        logic [4:0] ctl;
        logic [1:0] st;
        logic       er;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .src1(src1), .src2(src2), .two_src(two_src), .src_valid(src_valid),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .backend_freeze(backend_freeze),
        .err(err), .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input in_t v);
        src1 = v.src1; src2 = v.src2; two_src = v.two_src; src_valid = v.src_valid;
        ex_dest = v.ex_dest; ex_wb_en = v.ex_wb_en; ex_mem_r_en = v.ex_mem_r_en;
        mem_dest = v.mem_dest; mem_wb_en = v.mem_wb_en; forward_en = v.forward_en;
        branch_taken = v.branch_taken; mem_req = v.mem_req; mem_ready = v.mem_ready;
    endtask

    function automatic in_t f_load_use(input logic r_en, input logic fwd, input logic br);
        in_t v = '0;
        v.forward_en = fwd; v.ex_mem_r_en = r_en; v.ex_wb_en = 1'b1;
        v.ex_dest = 4'd3; v.src1 = 4'd3; v.src_valid = 1'b1; v.branch_taken = br;
        return v;
    endfunction

    function automatic in_t f_mem(input logic req, input logic rdy, input logic br);
        in_t v = '0;
        v.mem_req = req; v.mem_ready = rdy; v.branch_taken = br;
        return v;
    endfunction

    function automatic exp_t mk(input logic [4:0] c, input logic [1:0] s, input logic e,
                                input int sc, input int fc);
        exp_t x;
        x.ctl = c; x.st = s; x.er = e; x.sc = 4'(sc); x.fc = 4'(fc);
        return x;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t got;
        reset_n = 1'b0;
        drive(f_load_use(1'b1, 1'b1, 1'b1));
        sb.push_back(mk(C_IDLE, 2'd0, 1'b0, 0, 0));
        #1;
        got = sb.pop_front();
        checks++;
        if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
        end
        @(posedge clk); #1;
        checks++;
        if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
            errors++;
            $display("FAIL reset_regs got st=%0d err=%b sc=%0d fc=%0d exp all zero", state, err, stall_count, flush_count);
        end
        apply_reset();
    endtask

    // Shared step loop body is repeated per scenario so each keeps its own names.
    task automatic test_load_use();
        in_t  iq[$];
        exp_t got;
        apply_reset();
        iq.push_back(f_load_use(1'b1, 1'b1, 1'b0)); sb.push_back(mk(C_HAZ,  0, 0, 1, 0));
        iq.push_back(f_load_use(1'b0, 1'b1, 1'b0)); sb.push_back(mk(C_IDLE, 0, 0, 1, 0));
        iq.push_back(f_load_use(1'b0, 1'b0, 1'b0)); sb.push_back(mk(C_HAZ,  0, 0, 2, 0));
        foreach (iq[i]) begin
            @(negedge clk); drive(iq[i]); #1;
            got = sb.pop_front();
            checks++;
            if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
                errors++;
                $display("FAIL load_use_ctl step %0d got %b exp %b", i, {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
            end
            @(posedge clk); #1;
            checks++;
            if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
                errors++;
                $display("FAIL load_use_regs step %0d got st=%0d err=%b sc=%0d fc=%0d exp st=%0d err=%b sc=%0d fc=%0d",
                         i, state, err, stall_count, flush_count, got.st, got.er, got.sc, got.fc);
            end
        end
    endtask

    task automatic test_mem_hazard();
        in_t  iq[$];
        in_t  v;
        exp_t got;
        apply_reset();
        v = '0; v.mem_wb_en = 1'b1; v.mem_dest = 4'd5; v.src_valid = 1'b1;
        v.two_src = 1'b1; v.src2 = 4'd5; v.src1 = 4'd0;
        iq.push_back(v); sb.push_back(mk(C_HAZ, 0, 0, 1, 0));
        v.two_src = 1'b0; v.src1 = 4'd4;
        iq.push_back(v); sb.push_back(mk(C_IDLE, 0, 0, 1, 0));
        v.src1 = 4'd5; v.forward_en = 1'b1;
        iq.push_back(v); sb.push_back(mk(C_IDLE, 0, 0, 1, 0));
        v.forward_en = 1'b0;
        iq.push_back(v); sb.push_back(mk(C_HAZ, 0, 0, 2, 0));
        v.src_valid = 1'b0;
        iq.push_back(v); sb.push_back(mk(C_IDLE, 0, 0, 2, 0));
        foreach (iq[i]) begin
            @(negedge clk); drive(iq[i]); #1;
            got = sb.pop_front();
            checks++;
            if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
                errors++;
                $display("FAIL mem_hazard_ctl step %0d got %b exp %b", i, {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
            end
            @(posedge clk); #1;
            checks++;
            if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
                errors++;
                $display("FAIL mem_hazard_regs step %0d got st=%0d err=%b sc=%0d fc=%0d exp st=%0d err=%b sc=%0d fc=%0d",
                         i, state, err, stall_count, flush_count, got.st, got.er, got.sc, got.fc);
            end
        end
    endtask

    task automatic test_branch();
        in_t  iq[$];
        exp_t got;
        apply_reset();
        iq.push_back(f_load_use(1'b1, 1'b1, 1'b1)); sb.push_back(mk(C_BR,   0, 0, 0, 1));
        iq.push_back(f_mem(1'b0, 1'b0, 1'b1));      sb.push_back(mk(C_BR,   0, 0, 0, 2));
        iq.push_back(f_mem(1'b0, 1'b0, 1'b0));      sb.push_back(mk(C_IDLE, 0, 0, 0, 2));
        iq.push_back(f_mem(1'b1, 1'b1, 1'b1));      sb.push_back(mk(C_BR,   0, 0, 0, 3));
        foreach (iq[i]) begin
            @(negedge clk); drive(iq[i]); #1;
            got = sb.pop_front();
            checks++;
            if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
                errors++;
                $display("FAIL branch_ctl step %0d got %b exp %b", i, {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
            end
            @(posedge clk); #1;
            checks++;
            if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
                errors++;
                $display("FAIL branch_regs step %0d got st=%0d err=%b sc=%0d fc=%0d exp st=%0d err=%b sc=%0d fc=%0d",
                         i, state, err, stall_count, flush_count, got.st, got.er, got.sc, got.fc);
            end
        end
    endtask

    task automatic test_mem_wait();
        in_t  iq[$];
        exp_t got;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            iq.push_back(f_mem(1'b1, 1'b0, 1'b1)); sb.push_back(mk(C_FRZ, 1, 0, k + 1, 0));
        end
        iq.push_back(f_mem(1'b1, 1'b1, 1'b1)); sb.push_back(mk(C_IDLE, 0, 0, 4, 0));
        iq.push_back(f_mem(1'b0, 1'b0, 1'b1)); sb.push_back(mk(C_BR,   0, 0, 4, 1));
        // A second wait must start from a cleared wait counter and time out on schedule.
        for (int k = 0; k < 8; k++) begin
            iq.push_back(f_mem(1'b1, 1'b0, 1'b0));
            sb.push_back(mk(C_FRZ, (k == 7) ? 2'd2 : 2'd1, (k == 7), 5 + k, 1));
        end
        foreach (iq[i]) begin
            @(negedge clk); drive(iq[i]); #1;
            got = sb.pop_front();
            checks++;
            if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
                errors++;
                $display("FAIL mem_wait_ctl step %0d got %b exp %b", i, {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
            end
            @(posedge clk); #1;
            checks++;
            if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
                errors++;
                $display("FAIL mem_wait_regs step %0d got st=%0d err=%b sc=%0d fc=%0d exp st=%0d err=%b sc=%0d fc=%0d",
                         i, state, err, stall_count, flush_count, got.st, got.er, got.sc, got.fc);
            end
        end
    endtask

    task automatic test_timeout();
        in_t  iq[$];
        exp_t got;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            iq.push_back(f_mem(1'b1, 1'b0, 1'b0));
            sb.push_back(mk(C_FRZ, (k == 7) ? 2'd2 : 2'd1, (k == 7), k + 1, 0));
        end
        iq.push_back(f_mem(1'b1, 1'b1, 1'b1)); sb.push_back(mk(C_FRZ, 2, 1, 9, 0));
        iq.push_back(f_mem(1'b0, 1'b1, 1'b0)); sb.push_back(mk(C_FRZ, 2, 1, 10, 0));
        iq.push_back(f_mem(1'b1, 1'b0, 1'b0)); sb.push_back(mk(C_FRZ, 2, 1, 11, 0));
        foreach (iq[i]) begin
            @(negedge clk); drive(iq[i]); #1;
            got = sb.pop_front();
            checks++;
            if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
                errors++;
                $display("FAIL timeout_ctl step %0d got %b exp %b", i, {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
            end
            @(posedge clk); #1;
            checks++;
            if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
                errors++;
                $display("FAIL timeout_regs step %0d got st=%0d err=%b sc=%0d fc=%0d exp st=%0d err=%b sc=%0d fc=%0d",
                         i, state, err, stall_count, flush_count, got.st, got.er, got.sc, got.fc);
            end
        end
        // Reset pulse mid-ERROR with a memory stall still presented.
        reset_n = 1'b0;
        sb.push_back(mk(C_IDLE, 0, 0, 0, 0));
        #1;
        got = sb.pop_front();
        checks++;
        if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze, state, err, stall_count, flush_count}
            !== {got.ctl, got.st, got.er, got.sc, got.fc}) begin
            errors++;
            $display("FAIL timeout_reset got ctl=%b st=%0d err=%b sc=%0d fc=%0d exp all zero",
                     {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, state, err, stall_count, flush_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive('0);
        @(posedge clk); #1;
        checks++;
        if ({state, err} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_after_reset got st=%0d err=%b exp st=0 err=0", state, err);
        end
    endtask

    task automatic test_saturation();
        in_t  iq[$];
        exp_t got;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            iq.push_back(f_load_use(1'b1, 1'b1, 1'b0));
            sb.push_back(mk(C_HAZ, 0, 0, (k + 1 > 15) ? 15 : k + 1, 0));
        end
        foreach (iq[i]) begin
            @(negedge clk); drive(iq[i]); #1;
            got = sb.pop_front();
            checks++;
            if ({pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze} !== got.ctl) begin
                errors++;
                $display("FAIL saturation_ctl step %0d got %b exp %b", i, {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, backend_freeze}, got.ctl);
            end
            @(posedge clk); #1;
            checks++;
            if ({state, err, stall_count, flush_count} !== {got.st, got.er, got.sc, got.fc}) begin
                errors++;
                $display("FAIL saturation_regs step %0d got st=%0d err=%b sc=%0d fc=%0d exp st=%0d err=%b sc=%0d fc=%0d",
                         i, state, err, stall_count, flush_count, got.st, got.er, got.sc, got.fc);
            end
        end
    endtask

    initial begin
        drive('0);
        test_reset();
        test_load_use();
        test_mem_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences freeze/flush of the front-end pipeline registers (PC, IF/ID, ID/EX) and the back-end (EX/MEM, MEM/WB).
- Covers RAW data hazards in ID, taken-branch redirects from EX, and multi-cycle data-memory waits from MEM.
- Sits beside the datapath; its outputs drive the freeze/flush inputs of the stage registers.
- Also keeps saturating stall/flush performance counters and a memory-timeout error state.

Parameters:
REG_W, 4, register-address width
CNT_W, 16, width of each performance counter
MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before ERROR

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
src1  in  REG_W  first source register of the instruction in ID
src2  in  REG_W  second source register of the instruction in ID
two_src  in  1  ID instruction reads src2
src_valid  in  1  ID holds a valid instruction reading src1
ex_dest  in  REG_W  destination register in EX
ex_wb_en  in  1  EX instruction writes back
ex_mem_r_en  in  1  EX instruction is a load
mem_dest  in  REG_W  destination register in MEM
mem_wb_en  in  1  MEM instruction writes back
forward_en  in  1  forwarding unit enabled
branch_taken  in  1  EX resolves a taken branch this cycle
mem_req  in  1  MEM stage accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_freeze  out  1  hold PC
if_id_freeze  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID register
id_ex_flush  out  1  insert bubble into ID/EX
backend_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
err  out  1  memory timeout occurred; sticky
state  out  2  FSM state: RUN=0, MEM_WAIT=1, ERROR=2
stall_count  out  CNT_W  cycles with any freeze active
flush_count  out  CNT_W  branch flushes issued

Behaviour:
Reset (reset_n low, asynchronous):
- state=RUN; err=0; both counters=0; wait counter=0.
- All freeze/flush outputs 0 while in reset.

Hazard detect (combinational):
- raw_ex = src_valid & ex_wb_en & (src1==ex_dest | two_src & src2==ex_dest).
- raw_mem: same form using mem_dest and mem_wb_en.
- If forward_en=1: hazard = raw_ex & ex_mem_r_en (load-use only).
- Otherwise: hazard = raw_ex | raw_mem.

Outputs are combinational from state and inputs. There is zero-cycle latency: the action takes effect at the same clock edge.

RUN, priority highest first:
- mem_stall = mem_req & ~mem_ready:
  - pc_freeze, if_id_freeze and backend_freeze all = 1; no flush.
  - Next state MEM_WAIT.
  - A branch_taken in the same cycle is ignored; EX is held, so it re-presents after the wait.
- branch_taken:
  - if_id_flush=1 and id_ex_flush=1; all freezes 0.
  - Overrides hazard, because the ID instruction is wrong-path.
  - flush_count++.
- hazard:
  - pc_freeze=1, if_id_freeze=1, id_ex_flush=1 (one bubble per cycle while the hazard persists).
  - backend_freeze=0.

MEM_WAIT:
- pc_freeze, if_id_freeze and backend_freeze all = 1; wait counter++ each cycle.
- mem_ready=1: all freezes 0 in that cycle; next state RUN; wait counter cleared.
- Wait counter reaches MEM_TIMEOUT-1 without mem_ready: next state ERROR.

ERROR:
- All freezes = 1; err = 1.
- Only reset_n exits this state.

Counters:
- stall_count increments on every cycle in which pc_freeze or backend_freeze is 1, including ERROR.
- Both counters saturate at all-ones (no wrap).

Reset asserted mid-wait or mid-stall: immediate return to reset values; no pending state survives.

Test Plan:
- Load-use: forward_en=1, ex_mem_r_en=1, ex_wb_en=1, ex_dest=3, src1=3, src_valid=1 for 1 cycle -> pc_freeze=if_id_freeze=id_ex_flush=1 for that cycle; stall_count 0->1. Same with ex_mem_r_en=0 -> no freeze.
- No-forward MEM hazard: forward_en=0, mem_wb_en=1, mem_dest=5, two_src=1, src2=5 -> stall asserted; with two_src=0 and src1=4 -> none.
- Branch vs hazard: branch_taken=1 together with load-use hazard -> if_id_flush=id_ex_flush=1, pc_freeze=0; flush_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> backend_freeze high 4 cycles, state 1 then 0; simultaneous branch_taken produces no flush until RUN.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> state=2 and err=1 after 8 stall cycles, persisting; pulse reset_n low mid-ERROR -> state=0, err=0, counters=0.
- Saturation: CNT_W=4, 20 consecutive hazard cycles -> stall_count holds at 15.
